// File: rtl/neuron_loader_if.sv
// Stream, memory-write, result-read and output-port bundle between the
// neuron_loader and the host/Neuron side.
interface neuron_loader_if #(
  parameter int N = 16,
  parameter int Q = 8
);
  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         x_write;
  logic         w_write;
  logic [Q-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic         st;
  logic         done;
  logic         res_rd;
  logic [Q-1:0] res_addr;
  logic [N-1:0] res_data;
  logic         out_valid;
  logic [N-1:0] out_data;
  logic         out_ready;
  logic         busy;

  // master: the loader itself; slave: host stream, Neuron memories, consumer
  modport master (
    input  in_valid, in_data, done, res_data, out_ready,
    output in_ready, x_write, w_write, mem_addr, mem_wdata, st,
           res_rd, res_addr, out_valid, out_data, busy
  );
  modport slave (
    output in_valid, in_data, done, res_data, out_ready,
    input  in_ready, x_write, w_write, mem_addr, mem_wdata, st,
           res_rd, res_addr, out_valid, out_data, busy
  );
endinterface

// File: rtl/neuron_loader.sv
// Feeds one x vector and one weight vector into the Neuron memories, kicks
// the Neuron, then reads back the result word and offers it downstream.
module neuron_loader #(
  parameter int N        = 16,
  parameter int Q        = 8,
  parameter int d        = 3,
  parameter int LEN      = 8,
  parameter int X_BASE   = 0,
  parameter int W_BASE   = 0,
  parameter int RES_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  neuron_loader_if.master bus
);
  typedef enum logic [2:0] {
    LOAD_X, LOAD_W, DRAIN, START, WAIT_DONE, READ, CAPTURE, OUT
  } state_t;

  localparam logic [d-1:0] LAST = d'(LEN - 1);
  localparam logic [Q-1:0] XB   = Q'(X_BASE);
  localparam logic [Q-1:0] WB   = Q'(W_BASE);

  state_t       state;
  logic [d-1:0] idx;
  logic         xfer;

  assign bus.in_ready = (state == LOAD_X) || (state == LOAD_W);
  assign bus.busy     = !((state == LOAD_X) && (idx == '0));
  assign bus.res_addr = Q'(RES_ADDR);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= LOAD_X;
      idx           <= '0;
      bus.x_write   <= 1'b0;
      bus.w_write   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.st        <= 1'b0;
      bus.res_rd    <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      // strobes default low so each is a single-cycle pulse
      bus.x_write <= 1'b0;
      bus.w_write <= 1'b0;
      bus.st      <= 1'b0;
      bus.res_rd  <= 1'b0;
      case (state)
        LOAD_X, LOAD_W: begin
          if (xfer) begin
            bus.x_write   <= (state == LOAD_X);
            bus.w_write   <= (state == LOAD_W);
            bus.mem_addr  <= ((state == LOAD_X) ? XB : WB) + Q'(idx);
            bus.mem_wdata <= bus.in_data;
            if (idx == LAST) begin
              idx   <= '0;
              state <= (state == LOAD_X) ? LOAD_W : DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        // last weight write lands in DRAIN, so st never races it
        DRAIN: begin
          bus.st <= 1'b1;
          state  <= START;
        end
        START: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (bus.done) begin
            bus.res_rd <= 1'b1;
            state      <= READ;
          end
        end
        READ: state <= CAPTURE;
        CAPTURE: begin
          bus.out_data  <= bus.res_data;
          bus.out_valid <= 1'b1;
          state         <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state         <= LOAD_X;
          end
        end
        default: state <= LOAD_X;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_loader.sv
// Directed-plus-random bench for neuron_loader with a transaction-level
// model of expected memory writes and result timing.
module tb_neuron_loader;
  localparam int N = 8, Q = 8, D = 3, LEN = 4, XB = 0, WB = 8, RA = 5;

  typedef struct packed {
    logic [1:0]   kind;   // {x_write, w_write}
    logic [Q-1:0] addr;
    logic [N-1:0] data;
    logic [15:0]  cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  neuron_loader_if #(.N(N), .Q(Q)) bus();

  neuron_loader #(
    .N(N), .Q(Q), .d(D), .LEN(LEN), .X_BASE(XB), .W_BASE(WB), .RES_ADDR(RA)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  wr_t          got_q[$];
  wr_t          exp_q[$];
  wr_t          mon_e;
  logic [N-1:0] result_val = '0;
  bit           tog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result memory: read data appears one cycle after the strobe, junk otherwise
  always @(posedge clk) bus.res_data <= bus.res_rd ? result_val : N'($urandom);

  always @(negedge clk) begin
    if (bus.x_write || bus.w_write) begin
      mon_e.kind = {bus.x_write, bus.w_write};
      mon_e.addr = bus.mem_addr;
      mon_e.data = bus.mem_wdata;
      mon_e.cyc  = 16'(cyc);
      got_q.push_back(mon_e);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gap: 0 = in_valid constant, 1 = toggling, 2 = random
  task automatic send_words(input int n, input int gap, input bit seq, output int last_off);
    logic [N-1:0] v;
    wr_t          e;
    bit           got_it;
    int           guard;
    last_off = -1;
    for (int i = 0; i < n; i++) begin
      v      = seq ? N'(i + 1) : N'($urandom);
      got_it = 1'b0;
      guard  = 0;
      bus.in_data = v;
      while (!got_it && guard < 50) begin
        case (gap)
          0:       bus.in_valid = 1'b1;
          1:       begin tog = ~tog; bus.in_valid = tog; end
          default: bus.in_valid = 1'($urandom_range(0, 1));
        endcase
        if (bus.in_valid && bus.in_ready) begin
          e.kind   = (i < LEN) ? 2'b10 : 2'b01;
          e.addr   = Q'(((i < LEN) ? XB : WB) + (i % LEN));
          e.data   = v;
          e.cyc    = 16'(cyc + 1);
          exp_q.push_back(e);
          last_off = cyc;
          got_it   = 1'b1;
        end
        tick();
        guard++;
      end
      if (!got_it) chk("xfer_timeout", 64'd0, 64'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic compare_writes();
    chk("wr_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk("wr_entry", 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic finish_frame(input int last_off, input bit early, input int dly,
                              input int stall, input logic [N-1:0] res);
    int st_cyc;
    st_cyc     = -1;
    result_val = res;
    chk("drain_rdy", 64'(bus.in_ready), 64'd0);
    chk("drain_busy", 64'(bus.busy), 64'd1);
    for (int k = 0; k < 10 && st_cyc < 0; k++) begin
      tick();
      if (bus.st) st_cyc = cyc;
    end
    chk("st_cycle", 64'(st_cyc), 64'(last_off + 2));
    chk("start_rdy", 64'(bus.in_ready), 64'd0);
    if (early) bus.done = 1'b1;
    tick();
    bus.done     = 1'b0;
    bus.in_valid = 1'b1;
    chk("st_one_cycle", 64'(bus.st), 64'd0);
    for (int k = 1; k < dly; k++) begin
      chk("wait_rdy", 64'(bus.in_ready), 64'd0);
      chk("wait_no_rd", 64'(bus.res_rd), 64'd0);
      tick();
    end
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
    chk("res_rd", 64'(bus.res_rd), 64'd1);
    chk("res_addr", 64'(bus.res_addr), 64'(RA));
    chk("ov_early", 64'(bus.out_valid), 64'd0);
    tick();
    chk("res_rd_pulse", 64'(bus.res_rd), 64'd0);
    chk("ov_early2", 64'(bus.out_valid), 64'd0);
    tick();
    chk("out_valid", 64'(bus.out_valid), 64'd1);
    chk("out_data", 64'(bus.out_data), 64'(res));
    bus.in_valid = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_ov", 64'(bus.out_valid), 64'd1);
      chk("stall_od", 64'(bus.out_data), 64'(res));
      chk("stall_rdy", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("ov_clear", 64'(bus.out_valid), 64'd0);
    chk("rdy_back", 64'(bus.in_ready), 64'd1);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    compare_writes();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_xw"}, 64'(bus.x_write), 64'd0);
    chk({tag, "_ww"}, 64'(bus.w_write), 64'd0);
    chk({tag, "_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_st"}, 64'(bus.st), 64'd0);
    chk({tag, "_rd"}, 64'(bus.res_rd), 64'd0);
    chk({tag, "_ov"}, 64'(bus.out_valid), 64'd0);
    chk({tag, "_od"}, 64'(bus.out_data), 64'd0);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lo;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.done      = 1'b0;
    bus.out_ready = 1'b0;

    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // back-to-back frame: x 1..4, w 5..8, done shortly after
    send_words(2 * LEN, 0, 1'b1, lo);
    finish_frame(lo, 1'b0, 2, 0, 8'h3c);

    // gapped input, done held during START, late done, long output stall
    send_words(2 * LEN, 1, 1'b0, lo);
    finish_frame(lo, 1'b1, 5, 10, 8'h46);

    // reset after three words: writes stop at once, next frame restarts at idx 0
    send_words(3, 0, 1'b0, lo);
    #2 rst = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    chk("pre_rst_writes", 64'(got_q.size()), 64'd2);
    got_q.delete();
    exp_q.delete();
    rst = 1'b0;
    tick();

    for (int f = 0; f < 4; f++) begin
      send_words(2 * LEN, 2, 1'b0, lo);
      finish_frame(lo, 1'($urandom_range(0, 1)), $urandom_range(1, 8),
                   $urandom_range(0, 4), N'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
